// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmitter and receiver.
//   UART_CLKS_PER_BIT : clocks per serial bit (the receiver samples on this grid)
//   UART_DATA_BITS    : payload bits per frame, sent LSB first
//   UART_FRAME_BITS   : start + data + parity + stop
//   PARITY_EVEN/ODD   : parity seed; the parity bit is seed ^ (^data)
//   uart_state_t      : serialiser state encoding
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 16;
   localparam int UART_DATA_BITS    = 8;
   localparam int UART_FRAME_BITS   = 11;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   function automatic logic parity_bit(input logic mode, input logic [UART_DATA_BITS-1:0] data);
      return mode ^ (^data);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte write port of the UART transmitter.
//   din   : byte to transmit (producer -> transmitter)
//   wrsig : write request; a byte moves on an edge with wrsig && ready
//   ready : transmitter can take a byte (FIFO not full)
// Modports: master = byte producer, slave = transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] din;
   logic                      wrsig;
   logic                      ready;

   modport master (output din, output wrsig, input ready);
   modport slave  (input din, input wrsig, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO buffering bytes ahead of the serialiser.
//   clk, rst : clock and synchronous active-high reset (flushes the FIFO)
//   push/din : write; ignored when full, even if a pop happens in the same cycle
//   pop/dout : dout always shows the head so the serialiser can load it on the
//              same edge it pops; pop is ignored when empty
//   full, empty, level : status; level is the current occupancy
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign level   = count_reg;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-serialising UART transmitter.
// Frames are start(0), 8 data bits LSB first, parity, stop(1); each bit lasts
// CLKS_PER_BIT clocks, so one frame is 11*CLKS_PER_BIT clocks. Queued bytes go
// out back to back: the end of a stop bit loads the next byte directly.
//   clk, rst : clock and synchronous active-high reset
//   wr       : byte write port (din, wrsig, ready = ~full)
//   tx       : registered serial line, idle high
//   busy     : serialiser not idle
//   level    : bytes waiting in the FIFO (excludes the one being shifted)
module uart_tx
   import uart_pkg::*;
#(
   parameter int   CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter logic PARITY_MODE  = PARITY_EVEN,
   parameter int   FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_if.slave                      wr,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(UART_DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

   uart_state_t               state_reg;
   logic [BAUD_W-1:0]         baud_reg;
   logic [BIT_W-1:0]          bit_reg;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic                      parity_reg;
   logic                      tx_reg;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic [UART_DATA_BITS-1:0] fifo_head;
   logic                      baud_done;

   assign baud_done = (baud_reg == BAUD_LAST);
   assign wr.ready  = ~fifo_full;
   assign fifo_push = wr.wrsig & ~fifo_full;
   // A byte leaves the FIFO exactly when the FSM loads the shifter: from IDLE,
   // or on the last clock of a stop bit for back-to-back frames.
   assign fifo_pop  = ~fifo_empty &
                      ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_done));

   assign tx   = tx_reg;
   assign busy = (state_reg != ST_IDLE);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (wr.din),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         baud_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
         tx_reg     <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               baud_reg <= '0;
               tx_reg   <= 1'b1;
               if (!fifo_empty) begin
                  shift_reg  <= fifo_head;
                  parity_reg <= parity_bit(PARITY_MODE, fifo_head);
                  tx_reg     <= 1'b0;
                  state_reg  <= ST_START;
               end
            end

            ST_START: begin
               if (baud_done) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  tx_reg    <= shift_reg[0];
                  state_reg <= ST_DATA;
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end

            ST_DATA: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (bit_reg == BIT_LAST) begin
                     tx_reg    <= parity_reg;
                     state_reg <= ST_PARITY;
                  end else begin
                     // tx is registered, so drive the bit that is about to
                     // become shifter[0] on this same edge.
                     shift_reg <= shift_reg >> 1;
                     tx_reg    <= shift_reg[1];
                     bit_reg   <= bit_reg + BIT_W'(1);
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end

            ST_PARITY: begin
               if (baud_done) begin
                  baud_reg  <= '0;
                  tx_reg    <= 1'b1;
                  state_reg <= ST_STOP;
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end

            ST_STOP: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (!fifo_empty) begin
                     shift_reg  <= fifo_head;
                     parity_reg <= parity_bit(PARITY_MODE, fifo_head);
                     tx_reg     <= 1'b0;
                     state_reg  <= ST_START;
                  end else begin
                     tx_reg    <= 1'b1;
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + BAUD_W'(1);
               end
            end

            default: begin
               baud_reg  <= '0;
               tx_reg    <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serialising UART transmitter that drives the serial line consumed by `uart_rx`. It accepts bytes through a valid/ready write port, buffers them in a small FIFO, and emits 11-bit frames: start bit, 8 data bits LSB first, a parity bit, and one stop bit. Bit timing is 16 clocks per bit, matching the receiver's sampling points. It sits between the byte producer (command/data logic) and the `tx` pin.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit. Must equal the receiver's 16-clock bit spacing.
- `PARITY_MODE`, 1'b0: parity seed. The parity bit is `PARITY_MODE ^ (^data)`: 0 gives even parity, 1 gives odd parity. Same convention as `uart_rx`.
- `FIFO_DEPTH`, 4: number of buffered bytes. Must be a power of 2, at least 2.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in 8: byte to transmit.
- `wrsig` in 1: write request. The byte is accepted on an edge where `wrsig && ready`.
- `ready` out 1: FIFO not full. Combinational `~full`.
- `tx` out 1: serial line. Registered, idle high.
- `busy` out 1: high whenever the FSM is not IDLE.
- `level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy. Excludes the byte currently in the shifter.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `ready`=1, `level`=0. FSM goes to IDLE and the FIFO is flushed. `wrsig` is ignored while `rst` is high.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if the FIFO is non-empty, pop the head into an 8-bit shifter, latch the parity bit, set `tx`<=0, and go to START.
- **START, DATA, PARITY, STOP:** each bit is held for exactly `CLKS_PER_BIT` cycles, counted by a baud counter running 0..`CLKS_PER_BIT`-1.
  - START: `tx`=0.
  - DATA: `tx`=shifter[0], shifting right at each bit boundary. Bit counter runs 0..7.
  - PARITY: `tx`=latched parity.
  - STOP: `tx`=1.
- **End of STOP:**
  - FIFO non-empty: pop the next byte and go directly to START. Back-to-back frames, no idle cycle.
  - FIFO empty: go to IDLE.
- **FIFO:**
  - Full: `ready`=0, and a write is not accepted even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full): `level` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits wide.
- **Reset mid-frame:** `tx` returns to 1 on the next edge, and the partial frame and all queued bytes are discarded. The next accepted byte produces a clean frame.

## Timing
- **Latency:** byte accepted at edge N with FSM in IDLE and FIFO empty gives `tx` falling after edge N+1.
- **Frame length:** exactly 11×`CLKS_PER_BIT` = 176 cycles. Consecutive queued frames have start edges 176 cycles apart.
- **Receiver alignment:** the receiver samples data bit k at 24+16k cycles after the start edge. This lands mid-bit given the 16-cycle bit period (≈2-cycle edge-detect slack included). The stop bit is sampled at 168, before the next start edge at 176.
- **Idle level:** `tx` never glitches low outside START or a data/parity 0.
- **Capacity:** `FIFO_DEPTH` bytes plus 1 in the shifter.

## Structure
- Package `uart_pkg` holds the constants shared with `uart_rx`:
  - `UART_CLKS_PER_BIT`=16
  - `UART_DATA_BITS`=8
  - `UART_FRAME_BITS`=11
  - the FSM state enum
  - the `PARITY_MODE` encoding
- Sub-module `uart_tx_fifo` (synchronous FIFO: push, pop, full, empty, level) is instantiated once. The FSM, shifter and baud counter live in `uart_tx`.

## Test plan
1. **Reset:** assert `rst` 3 cycles with `wrsig`=1 -> `tx`=1, `busy`=0, `ready`=1, `level`=0, and nothing is transmitted.
2. **Single byte, even parity:** write 0xA5 -> `tx` shows 0 for 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), parity 0, stop 1. Total 176 cycles, then `busy`=0. Loopback into `uart_rx` gives `dataout`=0xA5, `dataerror`=0, `frameerror`=0.
3. **Odd parity:** `PARITY_MODE`=1, write 0x07 -> parity bit 0. Loopback with `uart_rx` `paritymode`=1 gives `dataerror`=0.
4. **Burst past capacity:** hold `wrsig` with bytes 0x01..0x06.
   - Five bytes are accepted: one popped into the shifter, four queued.
   - `ready` drops with `level`=4, and 0x06 is held.
   - 0x06 is accepted when the second frame starts.
   - Six frames go out with start edges exactly 176 cycles apart, in order.
5. **Simultaneous push/pop:** `level`=1 at the end of a STOP bit with `wrsig`=1 -> `level` stays 1 and the next START begins with no gap.
6. **Reset mid-frame:** assert `rst` during the PARITY bit with `level`=2 -> `tx`=1 next edge, `level`=0, `busy`=0. A subsequent write of 0x3C transmits a correct frame and decodes cleanly.
